cmp_share_arbiter: RTL and testbench
====================================

# cmp_share_arbiter

Round-robin arbiter and sequencer that shares one magnitude comparator among several requesters.
- Each requester submits an operand pair over a valid/ready handshake.
- The block latches the pair, runs one compare and returns the result to the winning requester.
- It also holds the last result on the board's RGB LED outputs.
- It sits between the switch/stimulus front-ends and the single RGB indicator.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- WIDTH, 2: operand width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-low. One clock; reset is asynchronous and active-low.
- req_valid  input  NUM_REQ  per-requester request; held high until its req_ready pulse.
- req_a  input  NUM_REQ×WIDTH  operand a, packed, requester i at [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ×WIDTH  operand b, packed as req_a.
- req_ready  output  NUM_REQ  one-hot accept pulse, one cycle.
- resp_valid  output  1  result available.
- resp_ready  input  1  result consumer acknowledge.
- resp_id  output  $clog2(NUM_REQ)  index of the requester the result belongs to.
- resp_ge, resp_le, resp_ne  output  1  a>=b, a<=b, a!=b for the served pair.
- red, green, blue  output  1  LED copies of ge, le, ne; hold the last completed result.
- done_cnt  output  8  completed transactions, wraps 255→0.

## Operation
- FSM states: IDLE, CMP, RESP.
- IDLE:
  - If any req_valid is high, select the first set bit scanning upward from rr_ptr, wrapping at NUM_REQ-1→0.
  - Drive req_ready[winner]=1 combinationally in that cycle.
  - On the edge: latch a/b and the winner index, go to CMP.
  - With no request, stay in IDLE with req_ready all 0.
- CMP:
  - The comparator evaluates the latched operands.
  - On the edge: register ge/le/ne into the resp_* and red/green/blue registers, increment done_cnt, go to RESP.
- RESP:
  - resp_valid=1 and resp_id=latched winner.
  - Stay in RESP while resp_ready=0; resp_* remain stable.
  - On resp_valid&&resp_ready: resp_valid falls next cycle, rr_ptr ← winner+1 (mod NUM_REQ), go to IDLE.
- Only IDLE asserts req_ready. Requests that arrive during CMP/RESP wait.
- A requester that drops req_valid before being accepted is simply not served. This is not an error.
- Comparison is unsigned over WIDTH bits. For equal operands ge=le=1 and ne=0. Exactly one of {ge&&!le, le&&!ge, ge&&le} holds.
- Reset values:
  - state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_id=0.
  - resp_ge/le/ne=0, red/green/blue=0, done_cnt=0.
- When rst_n is asserted mid-transaction, the pending result is discarded and all outputs return to reset values immediately (asynchronous). After release the FSM starts in IDLE.

## Timing
- Accept edge = cycle 0 (req_ready high in the cycle before it).
- resp_valid is first high in cycle 2. Request-to-response latency is 2 cycles.
- LEDs and done_cnt update on the same edge as resp_valid rises.
- Minimum period between accepts is 3 cycles, when resp_ready is held high.
- Starvation bound: a continuously requesting port is accepted within NUM_REQ transactions.
- Simultaneous requests are resolved by rr_ptr only. No fixed priority exists beyond the scan order.
- resp_ready high outside RESP is ignored.
- req_a/req_b are sampled only on the accept edge and may change freely afterwards.

## Structure
- Package cmp_share_pkg contains:
  - state_e enum (IDLE, CMP, RESP).
  - cmp_res_t struct {ge, le, ne}.
  - LED_CNT_W=8 constant.
- Sub-module cmp_mag:
  - Purely combinational WIDTH-parameterised comparator.
  - Inputs a, b; output cmp_res_t.
  - Instantiated once in the top.
  - The top holds the FSM, round-robin pointer, operand/result registers and counter.

## Test plan
- Single request:
  - Stimulus: req_valid=4'b0001, a=2, b=1, resp_ready=1.
  - Response: req_ready[0] for one cycle; resp_valid two cycles later with resp_id=0, ge=1, le=0, ne=1; red=1, green=0, blue=1; done_cnt=1.
- Equal and less-than:
  - Stimulus: pairs (3,3) then (0,3) on port 2.
  - Response: ge=le=1, ne=0 for the first; ge=0, le=1, ne=1 for the second; LEDs follow each result.
- Round-robin:
  - Stimulus: all four ports request continuously; resp_ready=1.
  - Response: grant order 0,1,2,3,0. Each accept is 3 cycles apart.
- Backpressure:
  - Stimulus: resp_ready=0 for 5 cycles during RESP with another port requesting.
  - Response: resp_valid and resp_* stay stable; no req_ready; the next port is accepted the cycle after the handshake edge.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during CMP.
  - Response: all outputs go to 0 without waiting for a clock edge; no response is emitted; after release the next request is served from rr_ptr=0.
- Counter wrap:
  - Stimulus: complete 256 transactions.
  - Response: done_cnt reads 0 after the 256th.

Source files
------------

// File: rtl/cmp_share_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cmp_share_pkg
// Shared types and constants for the shared-comparator arbiter:
//   state_e    - sequencer states (IDLE, CMP, RESP)
//   cmp_res_t  - comparator result bundle {ge, le, ne}
//   LED_CNT_W  - width of the completed-transaction counter
// -----------------------------------------------------------------------------
package cmp_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic ge;
        logic le;
        logic ne;
    } cmp_res_t;

    localparam int LED_CNT_W = 8;

endpackage : cmp_share_pkg

// File: rtl/cmp_share_arbiter_if.sv
// -----------------------------------------------------------------------------
// cmp_share_if
// Request/response bus between the requester front-ends and the arbiter.
//   req_valid  [NUM_REQ]        per-requester request, held until req_ready
//   req_a/b    [NUM_REQ*WIDTH]  packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready  [NUM_REQ]        one-hot, one-cycle accept pulse
//   resp_valid/resp_ready       result handshake
//   resp_id    [$clog2(NUM_REQ)] index of the served requester
//   resp_ge/le/ne               comparison result for the served pair
// slave  : arbiter side.  master : requester/consumer side.
// -----------------------------------------------------------------------------
interface cmp_share_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 2
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [ID_W-1:0]          resp_id;
    logic                     resp_ge;
    logic                     resp_le;
    logic                     resp_ne;

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_ge, resp_le, resp_ne
    );

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_ge, resp_le, resp_ne
    );

endinterface : cmp_share_if

// File: rtl/cmp_share_arbiter_cmp_mag.sv
// -----------------------------------------------------------------------------
// cmp_mag
// Purely combinational unsigned magnitude comparator.
//   i_a, i_b [WIDTH]  operands
//   o_res   cmp_res_t {ge = a>=b, le = a<=b, ne = a!=b}
// -----------------------------------------------------------------------------
module cmp_mag
    import cmp_share_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output cmp_res_t         o_res
);

    always_comb begin
        o_res    = '0;
        o_res.ge = (i_a >= i_b);
        o_res.le = (i_a <= i_b);
        o_res.ne = (i_a != i_b);
    end

endmodule : cmp_mag

// File: rtl/cmp_share_arbiter.sv
// -----------------------------------------------------------------------------
// cmp_share_arbiter
// Round-robin arbiter/sequencer sharing one magnitude comparator among
// NUM_REQ requesters. Accepts one operand pair, compares it, returns the
// result to the winner and mirrors the last result on the RGB LEDs.
//   i_clk       system clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   bus         cmp_share_if.slave request/response bus
//   o_red       copy of last ge
//   o_green     copy of last le
//   o_blue      copy of last ne
//   o_done_cnt  completed transactions, wraps at 2^LED_CNT_W
// -----------------------------------------------------------------------------
module cmp_share_arbiter
    import cmp_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    cmp_share_if.slave           bus,
    output logic                 o_red,
    output logic                 o_green,
    output logic                 o_blue,
    output logic [LED_CNT_W-1:0] o_done_cnt
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_e                 r_state;
    state_e                 w_next_state;
    logic [ID_W-1:0]        r_rr_ptr;
    logic [ID_W-1:0]        r_id;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    cmp_res_t               r_res;
    logic [LED_CNT_W-1:0]   r_done_cnt;

    logic                   w_any;
    logic [ID_W-1:0]        w_winner;
    logic [ID_W:0]          w_sum;
    logic [ID_W-1:0]        w_idx;
    logic [ID_W:0]          w_rr_sum;
    logic [ID_W-1:0]        w_rr_next;
    logic                   w_accept;
    logic                   w_handshake;
    cmp_res_t               w_cmp;

    // Round-robin scan: first requester at or above r_rr_ptr, wrapping.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        w_idx    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(off);
            if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (ID_W+1)'(NUM_REQ);
            end
            w_idx = w_sum[ID_W-1:0];
            if (!w_any && bus.req_valid[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Pointer moves just past the served requester, modulo NUM_REQ.
    always_comb begin
        w_rr_sum = {1'b0, r_id} + (ID_W+1)'(1);
        if (w_rr_sum >= (ID_W+1)'(NUM_REQ)) begin
            w_rr_sum = '0;
        end
        w_rr_next = w_rr_sum[ID_W-1:0];
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_handshake  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_accept     = 1'b1;
                    w_next_state = CMP;
                end
            end
            CMP: begin
                w_next_state = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    w_handshake  = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    cmp_mag #(
        .WIDTH (WIDTH)
    ) u_cmp_mag (
        .i_a   (r_a),
        .i_b   (r_b),
        .o_res (w_cmp)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_id       <= '0;
            r_res      <= '0;
            r_done_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_id <= w_winner;
            end
            if (r_state == CMP) begin
                r_res      <= w_cmp;
                r_done_cnt <= r_done_cnt + LED_CNT_W'(1);
            end
            if (w_handshake) begin
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    // Operands are pure data: captured only on the accept edge, no reset.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_a <= bus.req_a[int'(w_winner)*WIDTH +: WIDTH];
            r_b <= bus.req_b[int'(w_winner)*WIDTH +: WIDTH];
        end
    end

    // req_ready is combinational, so it is gated by reset to keep it low
    // while rst_n is asserted even if requests are present.
    assign bus.req_ready  = (w_accept && i_rst_n) ? (NUM_REQ'(1) << w_winner) : '0;
    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_id    = r_id;
    assign bus.resp_ge    = r_res.ge;
    assign bus.resp_le    = r_res.le;
    assign bus.resp_ne    = r_res.ne;
    assign o_red          = r_res.ge;
    assign o_green        = r_res.le;
    assign o_blue         = r_res.ne;
    assign o_done_cnt     = r_done_cnt;

endmodule : cmp_share_arbiter

// File: tb/tb_cmp_share_arbiter.sv
module tb_cmp_share_arbiter;
    import cmp_share_pkg::*;

    localparam int N = 4;
    localparam int W = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       red, green, blue;
    logic [7:0] done_cnt;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [7:0] exp_cnt = 8'd0;

    cmp_share_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    cmp_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .bus        (bus),
        .o_red      (red),
        .o_green    (green),
        .o_blue     (blue),
        .o_done_cnt (done_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int p, input int a, input int b);
        bus.req_a[p*W +: W] = W'(a);
        bus.req_b[p*W +: W] = W'(b);
    endtask

    // Wait (bounded) until any req_ready is visible, then check the grant.
    task automatic wait_grant(input string tag, input logic [3:0] exp_grant);
        bit ok;
        ok = 1'b0;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready != '0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            total++;
            bad++;
            $error("FAIL %s_timeout observed=0 expected=%0h", tag, exp_grant);
        end else begin
            check(tag, bus.req_ready, exp_grant);
        end
    endtask

    // Called in the cycle of the grant; runs the transaction to completion.
    task automatic finish_txn(input int p, input logic [2:0] exp_res);
        tick();
        bus.req_valid = '0;
        exp_cnt++;
        check("cmp_valid_low", bus.resp_valid, 1'b0);
        tick();
        check("resp_valid", bus.resp_valid, 1'b1);
        check("resp_id", bus.resp_id, p);
        check("resp_res", {bus.resp_ge, bus.resp_le, bus.resp_ne}, exp_res);
        check("led", {red, green, blue}, exp_res);
        check("done_cnt", done_cnt, exp_cnt);
        tick();
        check("resp_fall", bus.resp_valid, 1'b0);
    endtask

    task automatic serve(input int p, input int a, input int b, input logic [2:0] exp_res);
        set_op(p, a, b);
        bus.resp_ready = 1'b1;
        bus.req_valid  = 4'(1) << p;
        wait_grant("grant", 4'(1) << p);
        finish_txn(p, exp_res);
    endtask

    task automatic full_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        exp_cnt = 8'd0;
    endtask

    initial begin
        int last;
        int a, b;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;

        // Reset state
        #2;
        check("rst_req_ready", bus.req_ready, 4'b0000);
        check("rst_resp_valid", bus.resp_valid, 1'b0);
        check("rst_resp_id", bus.resp_id, 2'd0);
        check("rst_res", {bus.resp_ge, bus.resp_le, bus.resp_ne}, 3'b000);
        check("rst_led", {red, green, blue}, 3'b000);
        check("rst_cnt", done_cnt, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single request: 2 vs 1 on port 0
        serve(0, 2, 1, 3'b101);
        // Equal then less-than on port 2
        serve(2, 3, 3, 3'b110);
        serve(2, 0, 3, 3'b011);

        // Reset during CMP: pointer is 3 here, so a post-reset grant to
        // port 1 (with ports 1 and 3 requesting) shows it returned to 0.
        set_op(3, 1, 0);
        bus.req_valid = 4'b1000;
        wait_grant("mid_grant", 4'b1000);
        tick();
        bus.req_valid = '0;
        #1;
        rst_n = 1'b0;
        bus.req_valid = 4'b1010;
        #1;
        check("mid_resp_valid", bus.resp_valid, 1'b0);
        check("mid_resp_id", bus.resp_id, 2'd0);
        check("mid_res", {bus.resp_ge, bus.resp_le, bus.resp_ne}, 3'b000);
        check("mid_led", {red, green, blue}, 3'b000);
        check("mid_cnt", done_cnt, 8'd0);
        check("mid_req_ready", bus.req_ready, 4'b0000);
        set_op(1, 1, 3);
        set_op(3, 3, 1);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 8'd0;
        wait_grant("post_rst_grant", 4'b0010);
        finish_txn(1, 3'b011);

        // Round-robin with all ports requesting from a fresh pointer
        full_reset();
        set_op(0, 2, 1);
        set_op(1, 1, 2);
        set_op(2, 3, 3);
        set_op(3, 0, 0);
        bus.resp_ready = 1'b1;
        bus.req_valid  = 4'b1111;
        last = 0;
        for (int k = 0; k < 5; k++) begin
            int p;
            logic [2:0] r;
            p = k % 4;
            r = (p == 0) ? 3'b101 : (p == 1) ? 3'b011 : 3'b110;
            wait_grant("rr_grant", 4'(1) << p);
            if (k > 0) check("rr_gap", cyc - last, 3);
            last = cyc;
            tick();
            tick();
            exp_cnt++;
            check("rr_id", bus.resp_id, p);
            check("rr_res", {bus.resp_ge, bus.resp_le, bus.resp_ne}, r);
            tick();
        end
        bus.req_valid = '0;

        // Backpressure: pointer is 1; port 1 served, port 3 waits
        set_op(1, 1, 2);
        set_op(3, 2, 2);
        bus.resp_ready = 1'b0;
        bus.req_valid  = 4'b0010;
        wait_grant("bp_grant", 4'b0010);
        tick();
        bus.req_valid = 4'b1000;
        tick();
        exp_cnt++;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", bus.resp_valid, 1'b1);
            check("bp_id", bus.resp_id, 2'd1);
            check("bp_res", {bus.resp_ge, bus.resp_le, bus.resp_ne}, 3'b011);
            check("bp_no_ready", bus.req_ready, 4'b0000);
            tick();
        end
        bus.resp_ready = 1'b1;
        tick();
        check("bp_released", bus.resp_valid, 1'b0);
        check("bp_next_grant", bus.req_ready, 4'b1000);
        finish_txn(3, 3'b110);

        // Counter wrap over 256 transactions
        full_reset();
        for (int i = 0; i < 256; i++) begin
            a = i % 4;
            b = (i / 4) % 4;
            serve(i % 4, a, b, {a >= b, a <= b, a != b});
        end
        check("wrap_cnt", done_cnt, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cmp_share_arbiter
